// File: rtl/ipv4_decoder_if.sv
// Word stream into the IPv4 header decoder and the parsed results / payload it forwards.
interface ipv4_decoder_if;
    logic [31:0] data;
    logic        start;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [7:0]  protocol;
    logic [15:0] len_payload;
    logic [31:0] data_ip;
    logic        wr_en;
    logic        start_udp;
    logic        ok;
    logic        fin;

    modport master (
        output data, start,
        input  src_ip, dest_ip, protocol, len_payload, data_ip, wr_en, start_udp, ok, fin
    );

    modport slave (
        input  data, start,
        output src_ip, dest_ip, protocol, len_payload, data_ip, wr_en, start_udp, ok, fin
    );
endinterface

// File: rtl/ipv4_decoder.sv
// IPv4 receive header stage: parses and validates the header, skips options,
// forwards payload words and kicks the downstream UDP decoder for valid UDP packets.
module ipv4_decoder (
    input  logic          clk,
    input  logic          reset,
    ipv4_decoder_if.slave bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WCNT_W = 14;
    localparam int unsigned CSUM_W = 16;
    localparam int unsigned LEN_W  = 16;
    localparam logic [7:0]  PROTO_UDP = 8'h11;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, FIN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    hdr_idx_q, hdr_idx_d;
    logic [WCNT_W-1:0]   words_left_q, words_left_d;
    logic [3:0]          ihl_q, ihl_d;
    logic [3:0]          version_q, version_d;
    logic                frag_q, frag_d;
    logic [CSUM_W-1:0]   csum_q, csum_d;
    logic                hdr_valid_q, hdr_valid_d;
    logic                first_q, first_d;

    logic [WORD_W-1:0]   src_ip_q, src_ip_d;
    logic [WORD_W-1:0]   dest_ip_q, dest_ip_d;
    logic [7:0]          protocol_q, protocol_d;
    logic [LEN_W-1:0]    len_payload_q, len_payload_d;
    logic [WORD_W-1:0]   data_ip_q, data_ip_d;
    logic                wr_en_q, wr_en_d;
    logic                start_udp_q, start_udp_d;
    logic                ok_q, ok_d;
    logic                fin_q, fin_d;

    logic [CSUM_W-1:0]   csum_next;
    logic [LEN_W-1:0]    hdr_bytes0;
    logic                abort0;
    logic [WCNT_W-1:0]   pay_words;
    logic                last_hdr;

    // One's-complement add of both halves of a word, end-around carries folded twice.
    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [WORD_W-1:0] word);
        logic [17:0] s;
        logic [16:0] t;
        s = 18'(acc) + 18'(word[31:16]) + 18'(word[15:0]);
        t = 17'(s[15:0]) + 17'(s[17:16]);
        return t[15:0] + 16'(t[16]);
    endfunction

    assign csum_next  = csum_add(csum_q, bus.data);
    assign hdr_bytes0 = {10'd0, bus.data[27:24], 2'b00};
    assign abort0     = (bus.data[27:24] < 4'd5) || (bus.data[15:0] < hdr_bytes0);
    assign pay_words  = WCNT_W'((17'(len_payload_q) + 17'd3) >> 2);
    assign last_hdr   = (hdr_idx_q == (ihl_q - 4'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hdr_idx_q     <= '0;
            words_left_q  <= '0;
            ihl_q         <= '0;
            version_q     <= '0;
            frag_q        <= 1'b0;
            csum_q        <= '0;
            hdr_valid_q   <= 1'b0;
            first_q       <= 1'b0;
            src_ip_q      <= '0;
            dest_ip_q     <= '0;
            protocol_q    <= '0;
            len_payload_q <= '0;
            data_ip_q     <= '0;
            wr_en_q       <= 1'b0;
            start_udp_q   <= 1'b0;
            ok_q          <= 1'b0;
            fin_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_idx_q     <= hdr_idx_d;
            words_left_q  <= words_left_d;
            ihl_q         <= ihl_d;
            version_q     <= version_d;
            frag_q        <= frag_d;
            csum_q        <= csum_d;
            hdr_valid_q   <= hdr_valid_d;
            first_q       <= first_d;
            src_ip_q      <= src_ip_d;
            dest_ip_q     <= dest_ip_d;
            protocol_q    <= protocol_d;
            len_payload_q <= len_payload_d;
            data_ip_q     <= data_ip_d;
            wr_en_q       <= wr_en_d;
            start_udp_q   <= start_udp_d;
            ok_q          <= ok_d;
            fin_q         <= fin_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hdr_idx_d     = hdr_idx_q;
        words_left_d  = words_left_q;
        ihl_d         = ihl_q;
        version_d     = version_q;
        frag_d        = frag_q;
        csum_d        = csum_q;
        hdr_valid_d   = hdr_valid_q;
        first_d       = first_q;
        src_ip_d      = src_ip_q;
        dest_ip_d     = dest_ip_q;
        protocol_d    = protocol_q;
        len_payload_d = len_payload_q;
        data_ip_d     = data_ip_q;
        wr_en_d       = wr_en_q;
        start_udp_d   = start_udp_q;
        ok_d          = ok_q;
        fin_d         = fin_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    version_d   = bus.data[31:28];
                    ihl_d       = bus.data[27:24];
                    csum_d      = csum_add('0, bus.data);
                    hdr_idx_d   = 4'd1;
                    frag_d      = 1'b0;
                    hdr_valid_d = 1'b0;
                    // A malformed length field ends the packet before any payload is touched.
                    if (abort0) begin
                        state_d = FIN;
                    end else begin
                        state_d       = HDR;
                        len_payload_d = bus.data[15:0] - hdr_bytes0;
                    end
                end
            end

            HDR: begin
                csum_d    = csum_next;
                hdr_idx_d = hdr_idx_q + 4'd1;
                case (hdr_idx_q)
                    4'd1:    frag_d     = bus.data[13] || (|bus.data[12:0]);
                    4'd2:    protocol_d = bus.data[23:16];
                    4'd3:    src_ip_d   = bus.data;
                    4'd4:    dest_ip_d  = bus.data;
                    default: ;
                endcase
                if (last_hdr) begin
                    hdr_valid_d  = (version_q == 4'd4) && (csum_next == 16'hFFFF) && !frag_q;
                    words_left_d = pay_words;
                    first_d      = 1'b1;
                    state_d      = (pay_words == '0) ? FIN : PAYLOAD;
                end
            end

            PAYLOAD: begin
                data_ip_d    = bus.data;
                wr_en_d      = hdr_valid_q;
                start_udp_d  = first_q && hdr_valid_q && (protocol_q == PROTO_UDP);
                first_d      = 1'b0;
                words_left_d = words_left_q - WCNT_W'(1);
                if (words_left_q == WCNT_W'(1)) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                data_ip_d   = '0;
                wr_en_d     = 1'b0;
                start_udp_d = 1'b0;
                fin_d       = 1'b1;
                ok_d        = hdr_valid_q;
            end
        endcase
    end

    assign bus.src_ip      = src_ip_q;
    assign bus.dest_ip     = dest_ip_q;
    assign bus.protocol    = protocol_q;
    assign bus.len_payload = len_payload_q;
    assign bus.data_ip     = data_ip_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.start_udp   = start_udp_q;
    assign bus.ok          = ok_q;
    assign bus.fin         = fin_q;
endmodule

// File: doc/ipv4_decoder.md
# ipv4_decoder

Receive-side IPv4 header stage that sits directly upstream of the UDP decoder. It accepts an IPv4 packet as a stream of 32-bit big-endian words, one per clock, starting at the IP header. It parses and validates the header, including the one's-complement header checksum, and skips any options. It then forwards the payload words, together with the addresses and payload length the UDP decoder needs for its pseudo-header, and issues a one-cycle start to that decoder when the packet is a valid UDP datagram.

## Interface
Parameters: none.

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high; forces IDLE and clears all outputs
- data  input  32  packet word; byte 0 in [31:24]
- start  input  1  high for one cycle with header word 0 on data; sampled only in IDLE
- src_ip  output  32  source address (header word 3)
- dest_ip  output  32  destination address (header word 4)
- protocol  output  8  protocol field
- len_payload  output  16  total_length − 4·IHL
- data_ip  output  32  payload word, registered
- wr_en  output  1  data_ip holds a valid payload word
- start_udp  output  1  one-cycle pulse coincident with the first payload word; connects to UDP decoder start
- ok  output  1  fin && header valid
- fin  output  1  packet fully consumed; sticky until reset

## Operation
- States: IDLE, HDR, PAYLOAD, FIN. Word index counter hdr_idx (4 bits); payload word counter words_left (14 bits).
- IDLE → HDR when start=1. Word 0 is sampled at that edge. Capture IHL=data[27:24], version=data[31:28], total_length=data[15:0].
- HDR: word 1 gives the MF flag in data[13] and frag_offset in data[12:0]. Word 2 gives protocol in data[23:16]. Words 3 and 4 are the source and destination addresses. Words 5..IHL−1 are options, used in the checksum only.
- Checksum: 16-bit one's-complement accumulation. Each header word adds data[31:16] + data[15:0] into the accumulator with end-around carry folded. The header checksum passes iff the final sum is 16'hFFFF.
- Early abort at word 0: if IHL<5 or total_length<4·IHL, go to FIN on the next edge with ok=0. No payload is forwarded.
- hdr_valid = version==4 && checksum pass && MF==0 && frag_offset==0. It is evaluated once the last header word has been accumulated.
- After header word IHL−1, compute W = ceil(len_payload/4). If W==0, go to FIN. Otherwise go to PAYLOAD with words_left=W.
- PAYLOAD: each edge registers data into data_ip and decrements words_left.
  - wr_en=1 only if hdr_valid; otherwise words are consumed silently.
  - start_udp=1 on the first payload word only, and only if hdr_valid && protocol==8'h11.
  - The last word's unused trailing bytes are passed through unmasked.
- After the last payload word: FIN. In FIN, data_ip=0, wr_en=0, fin=1, ok=hdr_valid. FIN holds until reset.
- start is ignored outside IDLE.
- Arithmetic: len_payload = total_length − {IHL,2'b00}, 16-bit and never negative because of the early-abort check. W = (len_payload+3)>>2.

## Timing
- Reset values: every output is 0, state=IDLE, accumulator=0. Reset in any state, including mid-payload, returns to IDLE on that edge. No pulse on start_udp or fin is generated.
- Edge numbering: edge 0 samples start together with word 0. Edge k samples word k.
- src_ip is valid after edge 3. dest_ip is valid after edge 4. protocol and len_payload are valid after edge 2, and all remain stable until reset.
- Payload word n is sampled at edge IHL+n and appears on data_ip/wr_en after that edge. Latency is 1 cycle. start_udp is high in the same cycle as payload word 0.
- fin rises after edge IHL+W. For the early abort, fin rises after edge 1.
- Throughput: one word per clock with no stalls. The upstream source must not gap words.

## Test plan
- Valid UDP packet, header 45000073 00004000 4011B861 C0A80001 C0A800C7 followed by 24 payload words → src_ip=C0A80001, dest_ip=C0A800C7, len_payload=95. start_udp and the first wr_en occur after edge 5, with 24 consecutive wr_en cycles. fin and ok go high after edge 29.
- Same header with the checksum field changed to B862 → wr_en and start_udp never assert. fin goes high after edge 29 with ok=0.
- IHL=6 (one option word, header checksum recomputed and correct) → the option word is excluded from data_ip. The first payload word appears after edge 6.
- Protocol changed to 06 with a correct checksum → wr_en is high for all payload words, start_udp stays 0, ok=1.
- Word 0 = 44000014 (IHL=4) → fin=1 and ok=0 after edge 1. No wr_en.
- Reset asserted while in PAYLOAD (payload word 3) → all outputs are 0 on the next cycle. A new start afterwards parses a fresh packet correctly.
